// File: rtl/ram_fifo_stream_ctrl.sv
// ram_fifo_stream_ctrl
// Runs a two-port RAM as a synchronous FIFO. Words come in on a valid/ready
// push stream and go straight into the RAM. A prefetch stage reads the RAM
// ahead of the consumer so the RAM's one-cycle read latency is hidden. Both
// streams can move one word per cycle.
//
// Handshake (both streams): a transfer happens in a cycle where valid and
// ready are both high at the rising edge. A source holding valid keeps its
// data stable until that transfer. This block never drops popValid and never
// changes popData while a word waits for popReady.
//
// Occupancy is the RAM count plus an in-flight read plus a 2-entry output
// buffer, so the block holds up to DEPTH+2 words.
module ram_fifo_stream_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clockCore,
  input  logic              resetCore,
  // push stream
  input  logic              pushValid,
  input  logic [DATA_W-1:0] pushData,
  output logic              pushReady,
  // pop stream
  output logic              popValid,
  output logic [DATA_W-1:0] popData,
  input  logic              popReady,
  // status
  output logic [ADDR_W+1:0] wordCount,
  // RAM write port
  output logic              ramEnableWrite,
  output logic [ADDR_W-1:0] ramAddressWrite,
  output logic [DATA_W-1:0] ramWriteData,
  // RAM read port
  output logic              ramEnableRead,
  output logic [ADDR_W-1:0] ramAddressRead,
  input  logic [DATA_W-1:0] ramReadData
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int CNT_W = ADDR_W + 2;

  // Pointers carry one extra bit so that full and empty are told apart.
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              in_flight_q, in_flight_d;
  logic [1:0]        buf_count_q, buf_count_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;

  logic [PTR_W-1:0]  ram_count;
  logic [PTR_W-1:0]  ram_count_next;
  logic              push_ready;
  logic              push_fire;
  logic              pop_valid;
  logic              pop_fire;
  logic              issue;
  logic [2:0]        stage_occ;
  logic [2:0]        stage_limit;
  logic [1:0]        buf_after_pop;

  // Handshake and issue decisions for this cycle.
  always_comb begin
    ram_count  = wr_ptr_q - rd_ptr_q;
    push_ready = (ram_count != PTR_W'(DEPTH));
    push_fire  = pushValid & push_ready;
    pop_valid  = (buf_count_q != 2'd0);
    pop_fire   = pop_valid & popReady;
    // Issue a read only when the output stage can take the word next cycle.
    // The comparison is written as occ < 2 + popFire so nothing underflows.
    stage_occ   = {1'b0, buf_count_q} + {2'b00, in_flight_q};
    stage_limit = 3'd2 + {2'b00, pop_fire};
    issue       = (ram_count != '0) && (stage_occ < stage_limit);
  end

  // Next state for pointers, in-flight flag, output buffer and word count.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    in_flight_d   = issue;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    buf_count_d   = buf_count_q;
    buf_after_pop = buf_count_q;

    if (push_fire) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // A pop moves the second entry up into the head slot.
    if (pop_fire) begin
      buf0_d        = buf1_q;
      buf_after_pop = buf_count_q - 2'd1;
    end

    // The returning RAM word goes into the first slot left free after the pop.
    if (in_flight_q) begin
      if (buf_after_pop == 2'd0) begin
        buf0_d = ramReadData;
      end else begin
        buf1_d = ramReadData;
      end
      buf_count_d = buf_after_pop + 2'd1;
    end else begin
      buf_count_d = buf_after_pop;
    end

    ram_count_next = wr_ptr_d - rd_ptr_d;
    word_count_d   = CNT_W'(ram_count_next) + CNT_W'(in_flight_d) +
                     CNT_W'(buf_count_d);
  end

  // State registers. Reset also clears the in-flight flag, so a RAM word
  // that arrives after reset is ignored.
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      in_flight_q  <= 1'b0;
      buf_count_q  <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      word_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      in_flight_q  <= in_flight_d;
      buf_count_q  <= buf_count_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      word_count_q <= word_count_d;
    end
  end

  // Output drive. The write port passes the push stream straight through.
  always_comb begin
    pushReady       = push_ready;
    popValid        = pop_valid;
    popData         = buf0_q;
    wordCount       = word_count_q;
    ramEnableWrite  = push_fire;
    ramAddressWrite = wr_ptr_q[ADDR_W-1:0];
    ramWriteData    = pushData;
    ramEnableRead   = issue;
    ramAddressRead  = rd_ptr_q[ADDR_W-1:0];
  end

endmodule
